ttc_cmd_scheduler: RTL and testbench

//  Sequences the TTC encoder: arbitrates NREQ B-channel broadcast-command requesters round-robin and paces frames so a new
//  16-bit frame is only issued once the previous one has been serialized. Also conditions the L1A trigger onto a_channel

---
 rtl/ttc_pkg.sv | 19 +
 rtl/ttc_cmd_scheduler_if.sv | 25 ++
 rtl/ttc_rr_arbiter.sv | 38 +++
 rtl/ttc_cmd_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ttc_cmd_scheduler.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttc_pkg.sv
// Shared types and constants for the TTC command scheduler:
// FSM state encoding, frame width and the idle frame pattern.
package ttc_pkg;

   localparam int TTC_FRAME_W = 16;
   localparam logic [TTC_FRAME_W-1:0] TTC_IDLE_FRAME = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY
   } ttc_state_e;

   // Index width for a vector of n entries; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ttc_cmd_scheduler_if.sv
// B-channel requester bus: per-requester valid/data held until a one-cycle ready.
// The requester side uses the master modport, the scheduler the slave modport.
interface ttc_cmd_scheduler_if
   import ttc_pkg::*;
#(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]             req_valid;
   logic [NREQ*TTC_FRAME_W-1:0] req_data;
   logic [NREQ-1:0]             req_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/ttc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping around, returned as a one-hot grant plus its index.
module ttc_rr_arbiter
   import ttc_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = idx_w(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic w_found;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path can infer a latch.
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      o_any   = |i_req;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(i_ptr) + k;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!w_found && i_req[j[IDX_W-1:0]]) begin
            w_found                 = 1'b1;
            o_grant[j[IDX_W-1:0]]   = 1'b1;
            o_idx                   = j[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ttc_cmd_scheduler.sv
// TTC encoder sequencer: round-robin B-channel frame issue with fixed pacing and
// L1A conditioning with holdoff. Optional statistics counters under TTC_SCHED_STATS_EN.
module ttc_cmd_scheduler
   import ttc_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int BCMD_SPACING = 68,
   parameter int TRIG_HOLDOFF = 4
) (
   input  logic                   clk160,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   trig_in,
   ttc_cmd_scheduler_if.slave     bus,
   output logic                   a_channel,
   output logic [TTC_FRAME_W-1:0] ttc_data,
   output logic                   ttc_data_valid,
   output logic                   busy,
   output logic [15:0]            trig_drop_cnt,
   output logic [31:0]            frame_cnt
);

   localparam int IDX_W = idx_w(NREQ);
   localparam int CNT_W = idx_w(BCMD_SPACING);
   localparam int HLD_W = idx_w(TRIG_HOLDOFF + 1);

   ttc_state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]       r_rr, w_rr_nxt, w_gidx;
   logic [NREQ-1:0]        w_grant, r_req_ready, w_req_ready_nxt;
   logic                   w_any, w_pick;
   logic [TTC_FRAME_W-1:0] r_ttc_data, w_ttc_data_nxt, w_pick_data;
   logic                   r_ttc_data_valid, w_valid_nxt;
   logic                   r_busy, w_busy_nxt;
   logic [HLD_W-1:0]       r_hold;
   logic                   r_a_channel, w_trig_accept;

   ttc_rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   always_comb begin
      w_pick_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_pick_data = bus.req_data[i*TTC_FRAME_W +: TTC_FRAME_W];
         end
      end
   end

   // busy drops on the last pacing cycle, the cycle in which the next pick is made.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_busy_nxt      = r_busy;
      w_rr_nxt        = r_rr;
      w_ttc_data_nxt  = r_ttc_data;
      w_valid_nxt     = 1'b0;
      w_req_ready_nxt = '0;
      w_pick          = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_busy_nxt = 1'b0;
            w_pick     = enable && w_any;
         end
         ST_ISSUE: begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = CNT_W'(BCMD_SPACING - 2);
            w_busy_nxt  = (BCMD_SPACING > 2);
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_pick      = enable && w_any;
            end else begin
               w_cnt_nxt  = r_cnt - 1'b1;
               w_busy_nxt = (r_cnt != CNT_W'(1));
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_pick) begin
         w_state_nxt     = ST_ISSUE;
         w_busy_nxt      = 1'b1;
         w_valid_nxt     = 1'b1;
         w_req_ready_nxt = w_grant;
         w_ttc_data_nxt  = w_pick_data;
         w_rr_nxt        = (w_gidx == IDX_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

   always_ff @(posedge clk160) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_rr             <= '0;
         r_ttc_data       <= TTC_IDLE_FRAME;
         r_ttc_data_valid <= 1'b0;
         r_req_ready      <= '0;
         r_busy           <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         r_rr             <= w_rr_nxt;
         r_ttc_data       <= w_ttc_data_nxt;
         r_ttc_data_valid <= w_valid_nxt;
         r_req_ready      <= w_req_ready_nxt;
         r_busy           <= w_busy_nxt;
      end
   end

   // A-channel path is fully independent of the B-channel FSM.
   assign w_trig_accept = enable && trig_in && (r_hold == '0);

   always_ff @(posedge clk160) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_a_channel <= 1'b0;
      end else begin
         r_a_channel <= w_trig_accept;
         if (w_trig_accept) begin
            r_hold <= HLD_W'(TRIG_HOLDOFF - 1);
         end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
         end
      end
   end

`ifdef TTC_SCHED_STATS_EN
   logic [15:0] r_trig_drop_cnt;
   logic [31:0] r_frame_cnt;
   logic        w_trig_drop;

   assign w_trig_drop = trig_in && !w_trig_accept;

   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk160) begin
      if (!rst_n) begin
         r_trig_drop_cnt <= '0;
         r_frame_cnt     <= '0;
      end else begin
         if (w_trig_drop && (r_trig_drop_cnt != '1)) begin
            r_trig_drop_cnt <= r_trig_drop_cnt + 1'b1;
         end
         if ((r_state == ST_ISSUE) && (r_frame_cnt != '1)) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign trig_drop_cnt = r_trig_drop_cnt;
   assign frame_cnt     = r_frame_cnt;
`else
   assign trig_drop_cnt = '0;
   assign frame_cnt     = '0;
`endif

   assign bus.req_ready   = r_req_ready;
   assign ttc_data        = r_ttc_data;
   assign ttc_data_valid  = r_ttc_data_valid;
   assign busy            = r_busy;
   assign a_channel       = r_a_channel;

endmodule

// File: tb/tb_ttc_cmd_scheduler.sv
// Self-checking bench for ttc_cmd_scheduler: directed scenarios plus a randomized phase,
// all compared every cycle against a transaction-level reference model.
module tb_ttc_cmd_scheduler;

   localparam int NREQ = 4;
   localparam int S    = 68;
   localparam int H    = 4;

   logic clk160 = 1'b0;
   always #5 clk160 = ~clk160;

   logic        rst_n, enable, trig_in;
   logic        a_channel, ttc_data_valid, busy;
   logic [15:0] ttc_data, trig_drop_cnt;
   logic [31:0] frame_cnt;

   ttc_cmd_scheduler_if #(.NREQ(NREQ)) bus ();

   ttc_cmd_scheduler #(
      .NREQ         (NREQ),
      .BCMD_SPACING (S),
      .TRIG_HOLDOFF (H)
   ) dut (
      .clk160         (clk160),
      .rst_n          (rst_n),
      .enable         (enable),
      .trig_in        (trig_in),
      .bus            (bus),
      .a_channel      (a_channel),
      .ttc_data       (ttc_data),
      .ttc_data_valid (ttc_data_valid),
      .busy           (busy),
      .trig_drop_cnt  (trig_drop_cnt),
      .frame_cnt      (frame_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Inputs applied during the cycle that ends at the edge being observed.
   logic            p_rst_n, p_en, p_trig;
   logic [NREQ-1:0] p_valid;
   logic [15:0]     p_data [NREQ];

   // Next values to drive.
   logic            drv_rst_n, drv_en, drv_trig;
   logic [NREQ-1:0] rq_valid;
   logic [15:0]     rq_data [NREQ];
   bit              rq_cont;
   int              rq_pnew;

   // Reference model state.
   int          m_last_pulse, m_last_acc, m_ptr;
   logic [15:0] m_data, m_drops;
   logic [31:0] m_frames;

   // Observations for directed scenarios.
   int obs_busy;
   int obs_grants [$];
   int obs_pulse  [$];
   int obs_a      [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic clear_obs();
      obs_busy = 0;
      obs_grants.delete();
      obs_pulse.delete();
      obs_a.delete();
   endtask

   task automatic cycle();
      logic            ev_valid, ev_a, ev_busy;
      logic [NREQ-1:0] ev_ready;
      logic [31:0]     exp_frames;
      int              g;
      @(negedge clk160);
      cyc++;
      ev_valid = 1'b0;
      ev_a     = 1'b0;
      ev_ready = '0;
      if (!p_rst_n) begin
         m_last_pulse = -1000;
         m_last_acc   = -1000;
         m_ptr        = 0;
         m_data       = 16'hFFFF;
         m_drops      = '0;
         m_frames     = '0;
         exp_frames   = '0;
      end else begin
         exp_frames = m_frames;
         if (p_en && (|p_valid) && (cyc - m_last_pulse >= S)) begin
            g            = rr_pick(p_valid, m_ptr);
            ev_valid     = 1'b1;
            ev_ready[g]  = 1'b1;
            m_data       = p_data[g];
            m_ptr        = (g + 1) % NREQ;
            m_last_pulse = cyc;
            if (m_frames != '1) m_frames++;
         end
         if (p_trig) begin
            if (p_en && (cyc - 1 - m_last_acc >= H)) begin
               ev_a       = 1'b1;
               m_last_acc = cyc - 1;
            end else if (m_drops != '1) begin
               m_drops++;
            end
         end
      end
      ev_busy = (cyc - m_last_pulse) < (S - 1);

      check("ttc_data_valid", ttc_data_valid, ev_valid);
      check("req_ready", bus.req_ready, ev_ready);
      check("ttc_data", ttc_data, m_data);
      check("busy", busy, ev_busy);
      check("a_channel", a_channel, ev_a);
`ifdef TTC_SCHED_STATS_EN
      check("trig_drop_cnt", trig_drop_cnt, m_drops);
      check("frame_cnt", frame_cnt, exp_frames);
`else
      check("trig_drop_cnt", trig_drop_cnt, 32'd0);
      check("frame_cnt", frame_cnt, 32'd0);
`endif

      if (busy) obs_busy++;
      if (a_channel) obs_a.push_back(cyc);
      if (ttc_data_valid) begin
         obs_pulse.push_back(cyc);
         for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs_grants.push_back(i);
      end

      for (int i = 0; i < NREQ; i++) begin
         if (rq_valid[i] && bus.req_ready[i]) begin
            if (rq_cont) rq_data[i] = 16'($urandom);
            else         rq_valid[i] = 1'b0;
         end else if (!rq_valid[i] && ($urandom_range(999, 0) < rq_pnew)) begin
            rq_valid[i] = 1'b1;
            rq_data[i]  = 16'($urandom);
         end
      end

      rst_n         = drv_rst_n;
      enable        = drv_en;
      trig_in       = drv_trig;
      bus.req_valid = rq_valid;
      for (int i = 0; i < NREQ; i++) bus.req_data[i*16 +: 16] = rq_data[i];
      p_rst_n = drv_rst_n;
      p_en    = drv_en;
      p_trig  = drv_trig;
      p_valid = rq_valid;
      for (int i = 0; i < NREQ; i++) p_data[i] = rq_data[i];
   endtask

   task automatic do_reset(input int n);
      rq_valid  = '0;
      rq_cont   = 1'b0;
      rq_pnew   = 0;
      drv_trig  = 1'b0;
      drv_en    = 1'b1;
      drv_rst_n = 1'b0;
      repeat (n) cycle();
      drv_rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      int t0, n2;
      rst_n = 1'b0; enable = 1'b1; trig_in = 1'b0;
      bus.req_valid = '0; bus.req_data = '0;
      p_rst_n = 1'b0; p_en = 1'b1; p_trig = 1'b0; p_valid = '0;
      drv_rst_n = 1'b0; drv_en = 1'b1; drv_trig = 1'b0;
      rq_valid = '0; rq_cont = 1'b0; rq_pnew = 0;
      for (int i = 0; i < NREQ; i++) begin
         p_data[i]  = '0;
         rq_data[i] = '0;
      end
      m_last_pulse = -1000; m_last_acc = -1000; m_ptr = 0;
      m_data = 16'hFFFF; m_drops = '0; m_frames = '0;

      // Reset held four cycles.
      do_reset(4);
      check("reset_ttc_data", ttc_data, 32'hFFFF);
      check("reset_busy", busy, 1'b0);

      // Single request from requester 1.
      rq_valid[1] = 1'b1;
      rq_data[1]  = 16'h2815;
      t0 = cyc + 1;
      clear_obs();
      repeat (80) cycle();
      check("single_npulses", obs_pulse.size(), 1);
      if (obs_pulse.size() == 1) begin
         check("single_latency", obs_pulse[0] - t0, 1);
         check("single_grant", obs_grants[0], 1);
      end
      check("single_busy_cycles", obs_busy, S - 1);
      check("single_data_hold", ttc_data, 32'h2815);

      // All four requesters continuously valid.
      do_reset(2);
      rq_cont  = 1'b1;
      rq_valid = '1;
      for (int i = 0; i < NREQ; i++) rq_data[i] = 16'($urandom);
      clear_obs();
      for (int k = 0; k < 400 && obs_pulse.size() < 5; k++) cycle();
      check("rr_npulses", obs_pulse.size(), 5);
      for (int k = 0; k < obs_grants.size(); k++) check("rr_order", obs_grants[k], k % NREQ);
      for (int k = 1; k < obs_pulse.size(); k++) check("rr_spacing", obs_pulse[k] - obs_pulse[k-1], S);
      cycle();
`ifdef TTC_SCHED_STATS_EN
      check("rr_frame_cnt", frame_cnt, 5);
`endif

      // Trigger held high for ten cycles.
      do_reset(2);
      clear_obs();
      t0 = cyc + 1;
      drv_trig = 1'b1;
      repeat (10) cycle();
      drv_trig = 1'b0;
      repeat (6) cycle();
      check("trig_npulses", obs_a.size(), 3);
      if (obs_a.size() == 3) begin
         check("trig_pulse0", obs_a[0] - t0, 1);
         check("trig_pulse1", obs_a[1] - t0, 5);
         check("trig_pulse2", obs_a[2] - t0, 9);
      end
`ifdef TTC_SCHED_STATS_EN
      check("trig_drops", trig_drop_cnt, 7);
`endif

      // enable falls mid-frame with requester 2 pending.
      do_reset(2);
      rq_valid[0] = 1'b1;
      rq_data[0]  = 16'($urandom);
      clear_obs();
      for (int k = 0; k < 5 && obs_pulse.size() == 0; k++) cycle();
      check("en_first_pulse", obs_pulse.size(), 1);
      rq_valid[2] = 1'b1;
      rq_data[2]  = 16'($urandom);
      repeat (9) cycle();
      drv_en = 1'b0;
      repeat (100) cycle();
      n2 = 0;
      foreach (obs_grants[k]) if (obs_grants[k] == 2) n2++;
      check("en_no_grant2", n2, 0);
      check("en_idle_busy", busy, 1'b0);
      drv_en = 1'b1;
      repeat (3) cycle();
      check("en_resume_grant", obs_grants[obs_grants.size()-1], 2);

      // Reset mid-BUSY with requests pending restarts the rotation at requester 0.
      do_reset(2);
      rq_cont  = 1'b1;
      rq_valid = '1;
      for (int i = 0; i < NREQ; i++) rq_data[i] = 16'($urandom);
      clear_obs();
      for (int k = 0; k < 5 && obs_pulse.size() == 0; k++) cycle();
      check("rst_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);
      repeat (29) cycle();
      drv_rst_n = 1'b0;
      cycle();
      drv_rst_n = 1'b1;
      clear_obs();
      for (int k = 0; k < 5 && obs_pulse.size() == 0; k++) cycle();
      check("rst_after_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);

      // Randomized traffic, enable, triggers and occasional resets.
      do_reset(2);
      rq_pnew = 50;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(99, 0) == 0) drv_en = ~drv_en;
         drv_trig  = ($urandom_range(2, 0) == 0);
         drv_rst_n = ($urandom_range(799, 0) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
